gfx_command_queue: RTL and testbench
====================================

// Module: gfx_command_queue
// PURPOSE
//  Upstream of the graphics controller. Accepts CPU 68k-style register writes (X1, Y1, X2, Y2, Colour,
//  FillColour, Command) and queues each complete command in a FIFO. It replays queued commands onto the
//  graphics controller's register bus whenever the controller reports idle, so the CPU never polls per shape.
// PARAMETERS
//  DEPTH      8      FIFO entries; power of 2, 2..64
//  STROBE_CYC 2      cycles Gfx_AS_L held low per replayed write
//  GAP_CYC    2      cycles Gfx_AS_L held high after each replayed write
//  HOLDOFF    4      cycles after Command strobe before Gfx_Idle_H is trusted
// PORTS
//  Clk            in  1   system clock
//  Reset_H        in  1   reset; synchronous, active-high
//  AddressIn      in  7   CPU register index (CPU address bits [7:1])
//  DataInFromCPU  in  16  CPU write data
//  AS_L,RW        in  1   CPU address strobe (active low); RW=1 read, RW=0 write
//  UDS_L,LDS_L    in  1   byte strobes: UDS_L gates [15:8], LDS_L gates [7:0]
//  GraphicsCS_L   in  1   chip select from address decoder
//  DataOutToCPU   out 16  read data, registered
//  Gfx_Idle_H     in  1   graphics controller in its Idle state
//  Gfx_AddressOut out 7   replay register index
//  Gfx_DataOut    out 16  replay data
//  Gfx_AS_L, Gfx_CS_L, Gfx_UDS_L, Gfx_LDS_L, Gfx_RW  out 1  replay bus strobes
// BEHAVIOUR
//  Reset: FIFO empty, staging regs 0, Overflow 0, DataOutToCPU 0, Gfx_AddressOut/Gfx_DataOut 0, all
//   Gfx_* strobes 1, Gfx_RW 1, FSM IDLE. Reset mid-replay aborts it; Gfx_AS_L high at the next edge.
//  CPU write accept: GraphicsCS_L=0 & AS_L=0 & RW=0 & AS_L sampled 1 the previous cycle.
//   Exactly one accept occurs per AS_L assertion.
//   Index 1/2/3/4/7/8 -> X1/Y1/X2/Y2/Colour/FillColour staging; byte lanes per UDS_L/LDS_L.
//   Index 0 pushes {staged fields, DataInFromCPU} as one entry. Staging regs keep their values.
//   Index 7'h3F clears Overflow. Other indices are ignored.
//  Push when full: entry dropped and Overflow set (sticky). Push and pop in the same cycle: both occur,
//   count unchanged.
//  CPU read: each cycle with CS_L=0, AS_L=0, RW=1, DataOutToCPU <= staged reg for indices 1-8.
//   Index 7'h3F returns {Overflow,Full,Empty,Busy,5'b0,count[6:0]}. Other indices return 0.
//  Replay FSM:
//   IDLE      -> LOAD when !Empty & Gfx_Idle_H.
//   LOAD      pop entry into replay regs; field ptr=0.
//   W_SETUP   drive index/data; Gfx_CS_L=0, Gfx_RW=0, UDS/LDS=0, AS_L=1; 1 cycle.
//   W_STROBE  Gfx_AS_L=0 for STROBE_CYC cycles.
//   W_GAP     Gfx_AS_L=1 for GAP_CYC cycles. Then go to the next field's W_SETUP, or to HOLDOFF
//             after the Command field.
//   Field order: X1(1),Y1(2),X2(3),Y2(4),Colour(7),Fill(8),Command(0). Command is always last.
//   HOLDOFF   HOLDOFF cycles, then WAIT_IDLE.
//   WAIT_IDLE -> IDLE when Gfx_Idle_H; Gfx_CS_L=1, Gfx_RW=1.
//  Busy = FSM != IDLE.
//  Latency: a command pushed into an empty FIFO with Gfx_Idle_H=1 at edge N gives first Gfx_AS_L low
//   after edge N+3. Seven writes take 7*(1+STROBE_CYC+GAP_CYC)=35 cycles at defaults.
//  Pointers wrap modulo DEPTH. Count width covers DEPTH inclusive.
// TESTING
//  1 Write X1=360,Y1=360,X2=40,Y2=10,Col=4,Fill=4,Cmd=5 with Gfx_Idle_H=1 -> 7 replay strobes in order
//    1,2,3,4,7,8,0 with those data values; the first low strobe 3 cycles after the Cmd accept.
//  2 Hold Gfx_Idle_H=0 and push DEPTH+1 commands -> status Full=1, Overflow=1, count=DEPTH; the extra
//    command is never replayed. Write to 3F -> Overflow=0.
//  3 Push while replaying with count=DEPTH-1 -> count unchanged; all entries replay in FIFO order.
//  4 Hold AS_L low for 5 cycles on a Cmd write -> exactly one push (count +1).
//  5 Write X1=16'hABCD with UDS_L=1, LDS_L=0 -> X1 readback is 16'h00CD.
//  6 Assert Reset_H during W_STROBE -> Gfx_AS_L=1 after the next edge; status reads Empty=1, Busy=0.

Source files
------------

// File: rtl/gfx_command_queue.sv
// rtl/gfx_command_queue.sv - queues CPU graphics register writes and replays them to the graphics controller
module gfx_command_queue #(
  parameter int DEPTH      = 8,
  parameter int STROBE_CYC = 2,
  parameter int GAP_CYC    = 2,
  parameter int HOLDOFF    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_h,
  input  logic [6:0]  i_address_in,
  input  logic [15:0] i_data_in_from_cpu,
  input  logic        i_as_l,
  input  logic        i_rw,
  input  logic        i_uds_l,
  input  logic        i_lds_l,
  input  logic        i_graphics_cs_l,
  output logic [15:0] o_data_out_to_cpu,
  input  logic        i_gfx_idle_h,
  output logic [6:0]  o_gfx_address_out,
  output logic [15:0] o_gfx_data_out,
  output logic        o_gfx_as_l,
  output logic        o_gfx_cs_l,
  output logic        o_gfx_uds_l,
  output logic        o_gfx_lds_l,
  output logic        o_gfx_rw
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, W_SETUP, W_STROBE, W_GAP, S_HOLDOFF, WAIT_IDLE} state_t;

  state_t         r_state, w_next;
  logic [7:0]     r_cnt;
  logic [2:0]     r_ptr;
  logic [111:0]   r_fifo [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [15:0]    r_stage [6];
  logic [15:0]    r_rep [7];
  logic           r_overflow, r_as_l_prev;

  logic           w_accept, w_push, w_do_push, w_pop, w_full, w_empty, w_busy;
  logic           w_stage_hit;
  logic [2:0]     w_stage_sel;
  logic [111:0]   w_head;
  logic [15:0]    w_status;

  // One accept per AS_L assertion: only the first low cycle after a high one counts.
  assign w_accept  = !i_graphics_cs_l && !i_as_l && !i_rw && r_as_l_prev;
  assign w_push    = w_accept && (i_address_in == 7'd0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = w_push && !w_full;
  assign w_pop     = (r_state == LOAD);
  assign w_busy    = (r_state != IDLE);
  assign w_head    = r_fifo[r_rd_ptr];
  assign w_status  = {r_overflow, w_full, w_empty, w_busy, 5'b0, 7'(r_count)};

  always_comb begin
    w_stage_hit = 1'b1;
    w_stage_sel = 3'd0;
    case (i_address_in)
      7'd1:    w_stage_sel = 3'd0;
      7'd2:    w_stage_sel = 3'd1;
      7'd3:    w_stage_sel = 3'd2;
      7'd4:    w_stage_sel = 3'd3;
      7'd7:    w_stage_sel = 3'd4;
      7'd8:    w_stage_sel = 3'd5;
      default: w_stage_hit = 1'b0;
    endcase
  end

  function automatic logic [6:0] field_index(input logic [2:0] ptr);
    case (ptr)
      3'd0:    field_index = 7'd1;
      3'd1:    field_index = 7'd2;
      3'd2:    field_index = 7'd3;
      3'd3:    field_index = 7'd4;
      3'd4:    field_index = 7'd7;
      3'd5:    field_index = 7'd8;
      default: field_index = 7'd0;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset_h) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_gfx_as_l  = 1'b1;
    o_gfx_cs_l  = 1'b1;
    o_gfx_rw    = 1'b1;
    o_gfx_uds_l = 1'b1;
    o_gfx_lds_l = 1'b1;
    if (r_state == W_SETUP || r_state == W_STROBE || r_state == W_GAP) begin
      o_gfx_cs_l  = 1'b0;
      o_gfx_rw    = 1'b0;
      o_gfx_uds_l = 1'b0;
      o_gfx_lds_l = 1'b0;
    end
    case (r_state)
      IDLE:      if (!w_empty && i_gfx_idle_h) w_next = LOAD;
      LOAD:      w_next = W_SETUP;
      W_SETUP:   w_next = W_STROBE;
      W_STROBE: begin
        o_gfx_as_l = 1'b0;
        if (r_cnt == 8'(STROBE_CYC - 1)) w_next = W_GAP;
      end
      W_GAP:     if (r_cnt == 8'(GAP_CYC - 1)) w_next = (r_ptr == 3'd6) ? S_HOLDOFF : W_SETUP;
      S_HOLDOFF: if (r_cnt == 8'(HOLDOFF - 1)) w_next = WAIT_IDLE;
      WAIT_IDLE: if (i_gfx_idle_h) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_h) begin
      r_as_l_prev       <= 1'b1;
      r_overflow        <= 1'b0;
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      r_ptr             <= '0;
      o_data_out_to_cpu <= '0;
      o_gfx_address_out <= '0;
      o_gfx_data_out    <= '0;
      for (int k = 0; k < 6; k++) r_stage[k] <= '0;
      for (int k = 0; k < 7; k++) r_rep[k] <= '0;
    end else begin
      r_as_l_prev <= i_as_l;
      if (w_accept && w_stage_hit) begin
        if (!i_uds_l) r_stage[w_stage_sel][15:8] <= i_data_in_from_cpu[15:8];
        if (!i_lds_l) r_stage[w_stage_sel][7:0]  <= i_data_in_from_cpu[7:0];
      end
      if (w_accept && i_address_in == 7'h3F) r_overflow <= 1'b0;
      if (w_push && w_full) r_overflow <= 1'b1;
      if (w_do_push) begin
        r_fifo[r_wr_ptr] <= {i_data_in_from_cpu, r_stage[5], r_stage[4], r_stage[3],
                             r_stage[2], r_stage[1], r_stage[0]};
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_pop) r_count <= r_count - 1'b1;

      if (!i_graphics_cs_l && !i_as_l && i_rw) begin
        if (w_stage_hit)                o_data_out_to_cpu <= r_stage[w_stage_sel];
        else if (i_address_in == 7'h3F) o_data_out_to_cpu <= w_status;
        else                            o_data_out_to_cpu <= '0;
      end

      // Replay regs snapshot the popped entry so the FIFO slot can be refilled mid-replay.
      if (r_state == LOAD) begin
        for (int k = 0; k < 7; k++) r_rep[k] <= w_head[16*k +: 16];
        r_ptr             <= 3'd0;
        o_gfx_address_out <= field_index(3'd0);
        o_gfx_data_out    <= w_head[15:0];
      end else if (r_state == W_GAP && w_next == W_SETUP) begin
        r_ptr             <= r_ptr + 3'd1;
        o_gfx_address_out <= field_index(r_ptr + 3'd1);
        o_gfx_data_out    <= r_rep[r_ptr + 3'd1];
      end
    end
  end
endmodule

// File: tb/tb_gfx_command_queue.sv
// tb/tb_gfx_command_queue.sv - scoreboard bench for gfx_command_queue
module tb_gfx_command_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_h = 1'b1;
  logic [6:0]  addr = '0;
  logic [15:0] din = '0;
  logic        as_l = 1'b1, rw = 1'b1, uds_l = 1'b0, lds_l = 1'b0, cs_l = 1'b1;
  logic        gfx_idle = 1'b0;
  logic [15:0] dout;
  logic [6:0]  gfx_addr;
  logic [15:0] gfx_data;
  logic        gfx_as_l, gfx_cs_l, gfx_uds_l, gfx_lds_l, gfx_rw;

  int checks = 0;
  int errors = 0;
  logic [22:0] exp_q[$];
  int n_pushed = 0;
  int n_started = 0;
  logic [15:0] m_stage [6];
  logic        m_ovf = 1'b0;
  logic        prev_as = 1'b1;

  gfx_command_queue #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset_h(reset_h), .i_address_in(addr), .i_data_in_from_cpu(din),
    .i_as_l(as_l), .i_rw(rw), .i_uds_l(uds_l), .i_lds_l(lds_l), .i_graphics_cs_l(cs_l),
    .o_data_out_to_cpu(dout), .i_gfx_idle_h(gfx_idle), .o_gfx_address_out(gfx_addr),
    .o_gfx_data_out(gfx_data), .o_gfx_as_l(gfx_as_l), .o_gfx_cs_l(gfx_cs_l),
    .o_gfx_uds_l(gfx_uds_l), .o_gfx_lds_l(gfx_lds_l), .o_gfx_rw(gfx_rw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  function automatic int fld(input logic [6:0] a);
    case (a)
      7'd1: return 0;
      7'd2: return 1;
      7'd3: return 2;
      7'd4: return 3;
      7'd7: return 4;
      7'd8: return 5;
      default: return -1;
    endcase
  endfunction

  // Reference model: staging with byte lanes, FIFO occupancy, replay order of each pushed command.
  task automatic model_apply(input logic [6:0] a, input logic [15:0] d, input logic u, input logic l);
    int f;
    logic [6:0] order [6];
    order = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd7, 7'd8};
    f = fld(a);
    if (f >= 0) begin
      if (!u) m_stage[f][15:8] = d[15:8];
      if (!l) m_stage[f][7:0]  = d[7:0];
    end else if (a == 7'h3F) begin
      m_ovf = 1'b0;
    end else if (a == 7'd0) begin
      if (n_pushed - n_started < DEPTH) begin
        for (int k = 0; k < 6; k++) exp_q.push_back({order[k], m_stage[k]});
        exp_q.push_back({7'd0, d});
        n_pushed++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic cpu_write(input logic [6:0] a, input logic [15:0] d, input logic u, input logic l,
                           input int hold);
    addr = a; din = d; uds_l = u; lds_l = l; rw = 1'b0; cs_l = 1'b0; as_l = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    as_l = 1'b1; cs_l = 1'b1; rw = 1'b1;
    model_apply(a, d, u, l);
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [6:0] a, output logic [15:0] v);
    addr = a; rw = 1'b1; cs_l = 1'b0; as_l = 1'b0;
    @(posedge clk);
    #1;
    v = dout;
    as_l = 1'b1; cs_l = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 4000; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (20) @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  function automatic logic [15:0] status(input logic ovf, input logic busy, input int cnt);
    return {ovf, cnt == DEPTH, cnt == 0, busy, 5'b0, 7'(cnt)};
  endfunction

  // Monitor: every falling replay strobe is one field write, compared in order against the model.
  always @(negedge clk) begin
    if (!reset_h && prev_as && !gfx_as_l) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL replay_unexpected actual=%h/%h required=none", gfx_addr, gfx_data);
      end else begin
        logic [22:0] e;
        e = exp_q.pop_front();
        if ({gfx_addr, gfx_data} !== e || gfx_cs_l !== 1'b0 || gfx_rw !== 1'b0 ||
            gfx_uds_l !== 1'b0 || gfx_lds_l !== 1'b0) begin
          errors++;
          $display("FAIL replay_write actual=%h/%h cs=%b rw=%b required=%h/%h cs=0 rw=0",
                   gfx_addr, gfx_data, gfx_cs_l, gfx_rw, e[22:16], e[15:0]);
        end
        if (gfx_addr == 7'd1) n_started++;
      end
    end
    prev_as = gfx_as_l;
  end

  initial begin
    logic [15:0] v;
    logic [6:0] faddr [6];
    int k;
    faddr = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd7, 7'd8};
    for (int i = 0; i < 6; i++) m_stage[i] = '0;

    repeat (3) @(posedge clk);
    #1 reset_h = 1'b0;
    chk("reset_dout", dout, 16'h0);
    chk("reset_gfx_as", gfx_as_l, 1'b1);
    chk("reset_gfx_cs", gfx_cs_l, 1'b1);
    chk("reset_gfx_rw", gfx_rw, 1'b1);
    chk("reset_gfx_addr_data", {gfx_addr, gfx_data}, 23'h0);
    cpu_read(7'h3F, v);
    chk("reset_status", v, 16'h2000);

    // byte-lane write: only the low lane lands
    cpu_write(7'd1, 16'hABCD, 1'b1, 1'b0, 1);
    cpu_read(7'd1, v);
    chk("x1_low_lane", v, 16'h00CD);

    // full shape with controller idle, first strobe latency measured from the Cmd accept
    gfx_idle = 1'b1;
    cpu_write(7'd1, 16'd360, 1'b0, 1'b0, 1);
    cpu_write(7'd2, 16'd360, 1'b0, 1'b0, 1);
    cpu_write(7'd3, 16'd40, 1'b0, 1'b0, 1);
    cpu_write(7'd4, 16'd10, 1'b0, 1'b0, 1);
    cpu_write(7'd7, 16'd4, 1'b0, 1'b0, 1);
    cpu_write(7'd8, 16'd4, 1'b0, 1'b0, 1);
    cpu_write(7'd0, 16'd5, 1'b0, 1'b0, 1);
    // task returns one cycle after the accept edge N, so the strobe after N+3 is the 3rd negedge here
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!gfx_as_l) break;
    end
    chk("first_strobe_latency", k, 3);
    drain();

    // AS held low for 5 cycles is a single push; then fill and overflow
    gfx_idle = 1'b0;
    @(posedge clk); #1;
    cpu_write(7'd0, 16'h0101, 1'b0, 1'b0, 5);
    cpu_read(7'h3F, v);
    chk("held_as_one_push", v, status(1'b0, 1'b0, 1));
    for (int i = 0; i < DEPTH; i++) cpu_write(7'd0, 16'h0200 + 16'(i), 1'b0, 1'b0, 1);
    cpu_read(7'h3F, v);
    chk("full_overflow_status", v, status(1'b1, 1'b0, DEPTH));
    cpu_write(7'h3F, 16'h0, 1'b0, 1'b0, 1);
    cpu_read(7'h3F, v);
    chk("overflow_cleared", v, status(1'b0, 1'b0, DEPTH));
    gfx_idle = 1'b1;
    drain();

    // push landing on the same edge as the pop keeps count at DEPTH-1
    gfx_idle = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH - 1; i++) cpu_write(7'd0, 16'h0300 + 16'(i), 1'b0, 1'b0, 1);
    gfx_idle = 1'b1;
    @(posedge clk); #1;
    cpu_write(7'd0, 16'h03FF, 1'b0, 1'b0, 1);
    cpu_read(7'h3F, v);
    chk("push_pop_same_cycle", v, {4'b0001, 5'b0, 7'(DEPTH - 1)});
    drain();

    // randomized mix of staging writes, readbacks and command pushes under a flickering idle
    for (int it = 0; it < 200; it++) begin
      int r;
      gfx_idle = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 5) begin
        cpu_write(faddr[$urandom_range(0, 5)], 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(1, 3));
      end else if (r < 7) begin
        int f;
        f = $urandom_range(0, 5);
        cpu_read(faddr[f], v);
        chk("stage_readback", v, m_stage[f]);
      end else if (n_pushed - n_started < DEPTH - 1) begin
        cpu_write(7'd0, 16'($urandom), 1'b0, 1'b0, 1);
      end else begin
        @(posedge clk); #1;
      end
    end
    gfx_idle = 1'b1;
    drain();

    // reset in the middle of a strobe aborts the replay
    cpu_write(7'd0, 16'h0777, 1'b0, 1'b0, 1);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!gfx_as_l) break;
    end
    chk("strobe_seen_before_reset", k < 50, 1'b1);
    reset_h = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_mid_strobe_as", gfx_as_l, 1'b1);
    reset_h = 1'b0;
    exp_q.delete();
    n_pushed = n_started;
    m_ovf = 1'b0;
    for (int i = 0; i < 6; i++) m_stage[i] = '0;
    cpu_read(7'h3F, v);
    chk("reset_mid_strobe_status", v, 16'h2000);
    repeat (50) @(posedge clk);
    #1;
    chk("no_replay_after_reset", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
